// File: rtl/spi_dac_master.sv
// SPI master that serialises DAC words MSB first behind a valid/ready write port.
// Optional auto-refresh resends the shadow word whenever idle.
module spi_dac_master #(
  parameter int WORD_WIDTH  = 24,
  parameter int HALF_DIV    = 11,
  parameter int GAP_PERIODS = 5,
  parameter logic [WORD_WIDTH-1:0] INIT_WORD = WORD_WIDTH'(24'h007F22)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_refresh,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_spi_sclk,
  output logic                  o_spi_mosi,
  output logic                  o_spi_sync_n
);

  localparam int HW      = $clog2(HALF_DIV + 1);
  localparam int BW      = $clog2(WORD_WIDTH + 1);
  localparam int GAP_LEN = 2 * HALF_DIV * GAP_PERIODS;
  localparam int GW      = $clog2(GAP_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WORD_WIDTH-1:0] shadow;
  logic [WORD_WIDTH-1:0] shreg;
  logic [HW-1:0]         half_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  sclk_q;

  logic half_wrap;
  logic bit_last;
  logic gap_last;
  logic rise;

  assign half_wrap = (half_cnt == HW'(HALF_DIV - 1));
  assign bit_last  = (bit_cnt == BW'(WORD_WIDTH - 1));
  assign gap_last  = (gap_cnt == GW'(GAP_LEN - 1));
  assign rise      = half_wrap && !sclk_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_valid || i_refresh) state_nx = SHIFT;
      SHIFT:   if (rise && bit_last)     state_nx = GAP;
      GAP:     if (gap_last)             state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shift register is loaded on the accepting edge so a new word bypasses the shadow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow   <= INIT_WORD;
      shreg    <= '0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      sclk_q   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          half_cnt <= '0;
          bit_cnt  <= '0;
          gap_cnt  <= '0;
          sclk_q   <= 1'b1;
          if (i_valid) begin
            shadow <= i_data;
            shreg  <= i_data;
          end else if (i_refresh) begin
            shreg  <= shadow;
          end
        end
        SHIFT: begin
          if (half_wrap) begin
            half_cnt <= '0;
            sclk_q   <= ~sclk_q;
            if (!sclk_q) begin
              if (bit_last) begin
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                shreg   <= {shreg[WORD_WIDTH-2:0], 1'b0};
              end
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        GAP: begin
          sclk_q  <= 1'b1;
          gap_cnt <= gap_last ? '0 : gap_cnt + GW'(1);
        end
        default: begin
          sclk_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    o_ready      = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_spi_sync_n = 1'b1;
    o_spi_mosi   = 1'b0;
    o_spi_sclk   = sclk_q;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
      end
      SHIFT: begin
        o_spi_sync_n = 1'b0;
        o_spi_mosi   = shreg[WORD_WIDTH-1];
      end
      GAP: begin
        o_done = gap_last;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_dac_master.sv
// Directed bench for spi_dac_master: default build plus a fast 16-bit build.
// Frames are decoded from the pins on sclk falling edges.
module tb_spi_dac_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, valid0, refresh0;
  logic [23:0] data0;
  logic        ready0, busy0, done0, sclk0, mosi0, sync0;

  logic        rst1, valid1, refresh1;
  logic [15:0] data1;
  logic        ready1, busy1, done1, sclk1, mosi1, sync1;

  spi_dac_master d0 (
    .i_clk        (clk),
    .i_rst        (rst0),
    .i_data       (data0),
    .i_valid      (valid0),
    .o_ready      (ready0),
    .i_refresh    (refresh0),
    .o_busy       (busy0),
    .o_done       (done0),
    .o_spi_sclk   (sclk0),
    .o_spi_mosi   (mosi0),
    .o_spi_sync_n (sync0)
  );

  spi_dac_master #(
    .WORD_WIDTH  (16),
    .HALF_DIV    (1),
    .GAP_PERIODS (1),
    .INIT_WORD   (16'h7F22)
  ) d1 (
    .i_clk        (clk),
    .i_rst        (rst1),
    .i_data       (data1),
    .i_valid      (valid1),
    .o_ready      (ready1),
    .i_refresh    (refresh1),
    .o_busy       (busy1),
    .o_done       (done1),
    .o_spi_sclk   (sclk1),
    .o_spi_mosi   (mosi1),
    .o_spi_sync_n (sync1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Cycle k=1 is the first cycle after the accepting edge.
  task automatic frame(input int which, output logic [31:0] w,
                       output int low, output int falls,
                       output int done_at, output int rdy);
    logic ps, s, y, m, d, r;
    w = '0; low = 0; falls = 0; done_at = -1; rdy = 0; ps = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      s = which ? sclk1  : sclk0;
      y = which ? sync1  : sync0;
      m = which ? mosi1  : mosi0;
      d = which ? done1  : done0;
      r = which ? ready1 : ready0;
      if (!y) low++;
      if (!y && ps && !s) begin
        w = {w[30:0], m};
        falls++;
      end
      ps = s;
      if (r) rdy++;
      if (d) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic reset_state(input string tag);
    check({tag, "_sclk"},  32'(sclk0),  32'd1);
    check({tag, "_sync"},  32'(sync0),  32'd1);
    check({tag, "_mosi"},  32'(mosi0),  32'd0);
    check({tag, "_ready"}, 32'(ready0), 32'd1);
    check({tag, "_busy"},  32'(busy0),  32'd0);
    check({tag, "_done"},  32'(done0),  32'd0);
  endtask

  task automatic frame0(input string tag, input logic [23:0] exp_w);
    logic [31:0] w;
    int low, falls, dn, rdy;
    frame(0, w, low, falls, dn, rdy);
    check({tag, "_word"},  w,          32'(exp_w));
    check({tag, "_synclow"}, 32'(low), 32'd528);
    check({tag, "_falls"}, 32'(falls), 32'd24);
    check({tag, "_done"},  32'(dn),    32'd638);
    check({tag, "_rdy"},   32'(rdy),   32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int low, falls, dn, rdy;
    rst0 = 1'b1; valid0 = 1'b0; refresh0 = 1'b0; data0 = '0;
    rst1 = 1'b1; valid1 = 1'b0; refresh1 = 1'b0; data1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_state("rst");
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    reset_state("idle");

    // refresh after reset: INIT_WORD repeats every 639 cycles
    @(posedge clk); #1;
    refresh0 = 1'b1;
    @(posedge clk); #1;
    frame0("ref1", 24'h007F22);
    @(negedge clk);
    check("ref_gap_ready", 32'(ready0), 32'd1);
    frame0("ref2", 24'h007F22);
    #1 refresh0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;

    // single write
    data0 = 24'hA5C3F0; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    frame0("wr", 24'hA5C3F0);
    @(posedge clk); #1;
    check("wr_ready_after", 32'(ready0), 32'd1);

    // valid and refresh together: new data wins over shadow
    data0 = 24'h5A5A5A; valid0 = 1'b1; refresh0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0; refresh0 = 1'b0;
    frame0("both", 24'h5A5A5A);
    @(posedge clk); #1;

    // held valid while busy is back-pressured
    data0 = 24'h0F0F0F; valid0 = 1'b1;
    @(posedge clk); #1;
    data0 = 24'h123456;
    frame0("hold_old", 24'h0F0F0F);
    @(posedge clk); #1;
    check("hold_idle_ready", 32'(ready0), 32'd1);
    @(posedge clk); #1;
    valid0 = 1'b0;
    frame0("hold_new", 24'h123456);
    @(posedge clk); #1;

    // async reset during the 12th bit
    data0 = 24'hFFFFFF; valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    repeat (250) @(negedge clk);
    check("mid_sync", 32'(sync0), 32'd0);
    check("mid_mosi", 32'(mosi0), 32'd1);
    check("mid_busy", 32'(busy0), 32'd1);
    rst0 = 1'b1;
    #1;
    reset_state("async");
    @(posedge clk); #1;
    rst0 = 1'b0; refresh0 = 1'b1;
    @(posedge clk); #1;
    refresh0 = 1'b0;
    frame0("post_rst", 24'h007F22);

    // small build: 16 bits, sclk = clk/2, 2-cycle gap
    @(posedge clk); #1;
    check("s_ready", 32'(ready1), 32'd1);
    data1 = 16'hBEEF; valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    frame(1, w, low, falls, dn, rdy);
    check("s_word",    w,          32'h0000BEEF);
    check("s_synclow", 32'(low),   32'd32);
    check("s_falls",   32'(falls), 32'd16);
    check("s_done",    32'(dn),    32'd34);
    check("s_rdy",     32'(rdy),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_dac_master.md
Name: spi_dac_master

Overview:
- Parametrised SPI master that serialises DAC words; the generalised successor of the fixed 24-bit free-running DAC shifter in the top level.
- Adds a valid/ready write handshake, configurable word width, SCLK divider and inter-word gap, an optional auto-refresh mode and a completion pulse.
- Sits in the sysclk domain, between a control register (Wishbone CSR) and the spi_dac_* pins.

Parameters:
- WORD_WIDTH, 24: bits per SPI frame, MSB first; must be >= 2.
- HALF_DIV, 11: i_clk cycles per SCLK half-period; must be >= 1.
- GAP_PERIODS, 5: SCLK periods with sync_n held high after each frame; must be >= 1.
- INIT_WORD, 24'h007F22 (WORD_WIDTH wide): reset value of the shadow register.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_data  in  WORD_WIDTH  word to transmit.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  master can accept a word; high only in IDLE.
- i_refresh  in  1  auto-refresh: resend the shadow word whenever IDLE with no new word.
- o_busy  out  1  frame or gap in progress.
- o_done  out  1  one-cycle pulse on the last gap cycle.
- o_spi_sclk  out  1  SPI clock; idles high; DAC samples on the falling edge.
- o_spi_mosi  out  1  serial data.
- o_spi_sync_n  out  1  frame select, active low.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State returns to IDLE; shadow = INIT_WORD; all counters = 0.
  - Outputs: o_spi_sclk=1, o_spi_sync_n=1, o_spi_mosi=0, o_ready=1, o_busy=0, o_done=0.
- State machine: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE:
  - o_ready=1.
  - If i_valid: shadow <= i_data and a frame starts. i_valid takes priority over i_refresh.
  - Else if i_refresh: a frame starts with the unchanged shadow.
  - Else stay in IDLE.
  - Transition to SHIFT happens on the accepting edge.
  - i_data is ignored whenever o_ready=0; a held i_valid is accepted only on the next IDLE cycle.
- SHIFT, entered on the edge after acceptance:
  - A working shift register is loaded from the shadow.
  - sync_n=0 and mosi=MSB in the first SHIFT cycle.
  - The half-period counter counts 0..HALF_DIV-1. On wrap, sclk toggles.
  - On each rising (low-to-high) toggle, the shift register shifts left and mosi shows the next bit.
  - Each bit is stable for 2*HALF_DIV cycles, centred on the sclk falling edge.
  - After WORD_WIDTH full periods (2*HALF_DIV*WORD_WIDTH cycles) sclk is back high, sync_n goes 1, mosi goes 0, and the state moves to GAP.
- GAP:
  - sclk held 1, sync_n held 1.
  - Lasts 2*HALF_DIV*GAP_PERIODS cycles.
  - o_done=1 on the final GAP cycle; the state is IDLE on the next cycle.
- Frame time with defaults: SHIFT 528 cycles + GAP 110 cycles = 638 cycles from acceptance to o_done. Back-to-back throughput is 1 frame per 639 cycles.
- Writes during SHIFT or GAP are not accepted (handshake back-pressure). The shadow changes only on acceptance, so the frame in flight is never corrupted.
- Refresh mode with i_refresh held high reproduces the legacy continuous transmission of the shadow word.
- o_busy = (state != IDLE).
- o_ready and o_done are never high in the same cycle.
- Counters:
  - Bit counter width is clog2(WORD_WIDTH+1); gap counter is sized for 2*HALF_DIV*GAP_PERIODS.
  - All counters reset to 0 on each state entry.

Test Plan:
1. Reset, then i_valid=1 with i_data=24'hA5C3F0 for one cycle, default params: sync_n low for exactly 528 cycles, 24 sclk falling edges, bits sampled on falling edges = A5C3F0; o_done pulses 638 cycles after acceptance.
2. i_refresh=1, no i_valid, after reset: frames of 24'h007F22 repeat every 639 cycles; o_ready high exactly one cycle between frames.
3. i_valid held high while busy with a new word 24'h123456: not accepted until IDLE; the frame in flight keeps its old data; the next frame carries 123456.
4. Assert i_rst at the 12th bit of a frame: outputs immediately return to sclk=1, sync_n=1, mosi=0, ready=1; after release, i_refresh resends INIT_WORD.
5. WORD_WIDTH=16, HALF_DIV=1, GAP_PERIODS=1: 16 bits at i_clk/2, sync_n low 32 cycles, gap 2 cycles, o_done at cycle 34.
6. Simultaneous i_valid=1 and i_refresh=1 in IDLE: the new i_data is sent, not the old shadow.
